ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter_if.sv | 50 +++++
 rtl/ram_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - request, SDRAM-controller and refresh signals of the RAM arbiter
interface ram_arbiter_if;
  logic        spi_critical;
  logic        spi_refresh_inhibit;
  logic        spi_enable;
  logic        spi_write_enable;
  logic [1:0]  spi_write_mask;
  logic [31:0] spi_addr;
  logic [15:0] spi_write_data;
  logic        spi_data_valid;

  logic        host_enable;
  logic        host_write_enable;
  logic [1:0]  host_write_mask;
  logic [31:0] host_addr;
  logic [15:0] host_write_data;
  logic        host_data_valid;

  logic [31:0] ram_addr;
  logic [15:0] ram_write_data;
  logic [1:0]  ram_write_mask;
  logic        ram_enable;
  logic        ram_write_enable;
  logic        ram_data_valid;

  logic        refresh_req;
  logic        refresh_ack;
  logic [1:0]  owner;
  logic        refresh_overflow;

  modport slave (
    input  spi_critical, spi_refresh_inhibit, spi_enable, spi_write_enable,
           spi_write_mask, spi_addr, spi_write_data,
           host_enable, host_write_enable, host_write_mask, host_addr, host_write_data,
           ram_data_valid, refresh_ack,
    output spi_data_valid, host_data_valid,
           ram_addr, ram_write_data, ram_write_mask, ram_enable, ram_write_enable,
           refresh_req, owner, refresh_overflow
  );

  modport master (
    output spi_critical, spi_refresh_inhibit, spi_enable, spi_write_enable,
           spi_write_mask, spi_addr, spi_write_data,
           host_enable, host_write_enable, host_write_mask, host_addr, host_write_data,
           ram_data_valid, refresh_ack,
    input  spi_data_valid, host_data_valid,
           ram_addr, ram_write_data, ram_write_mask, ram_enable, ram_write_enable,
           refresh_req, owner, refresh_overflow
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - arbitrates SPI, host and refresh access to one SDRAM controller
module ram_arbiter #(
  parameter int REFRESH_INTERVAL = 780,
  parameter int REFRESH_URGENT   = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  ram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SPI     = 2'd1,
    HOST    = 2'd2,
    REFRESH = 2'd3
  } state_t;

  localparam int              CNT_W    = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]       URGENT   = 4'(REFRESH_URGENT);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] interval_cnt;
  logic [3:0]       credits;
  logic             overflow_q;
  logic             credit_add;
  logic             credit_take;
  logic             access_done;

  logic [31:0]      addr_q;
  logic [15:0]      wdata_q;
  logic [1:0]       wmask_q;
  logic             en_q;
  logic             we_q;

  assign access_done = ((state == SPI) || (state == HOST)) && bus.ram_data_valid;
  assign credit_add  = (interval_cnt == CNT_LAST);
  assign credit_take = (state == REFRESH) && bus.refresh_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Urgent refresh beats SPI; pending refresh beats host unless SPI holds its timing window.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (credits >= URGENT)
          state_next = REFRESH;
        else if (bus.spi_enable)
          state_next = SPI;
        else if ((credits != 4'd0) && !bus.spi_refresh_inhibit)
          state_next = REFRESH;
        else if (bus.host_enable && !bus.spi_critical)
          state_next = HOST;
      end
      SPI, HOST: begin
        if (bus.ram_data_valid)
          state_next = IDLE;
      end
      REFRESH: begin
        if (bus.refresh_ack)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.owner           = state;
    bus.refresh_req     = (state == REFRESH);
    bus.spi_data_valid  = (state == SPI)  && bus.ram_data_valid;
    bus.host_data_valid = (state == HOST) && bus.ram_data_valid;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      interval_cnt <= '0;
      credits      <= 4'd0;
      overflow_q   <= 1'b0;
    end else begin
      interval_cnt <= credit_add ? '0 : interval_cnt + CNT_W'(1);
      if (credit_add && !credit_take) begin
        if (credits == 4'hF)
          overflow_q <= 1'b1;
        else
          credits <= credits + 4'd1;
      end else if (!credit_add && credit_take) begin
        credits <= credits - 4'd1;
      end
    end
  end

  // Request is captured once on grant so the requester may change or drop its inputs mid-access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= 32'd0;
      wdata_q <= 16'd0;
      wmask_q <= 2'd0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
    end else if ((state == IDLE) && (state_next == SPI)) begin
      addr_q  <= bus.spi_addr;
      wdata_q <= bus.spi_write_data;
      wmask_q <= bus.spi_write_mask;
      en_q    <= 1'b1;
      we_q    <= bus.spi_write_enable;
    end else if ((state == IDLE) && (state_next == HOST)) begin
      addr_q  <= bus.host_addr;
      wdata_q <= bus.host_write_data;
      wmask_q <= bus.host_write_mask;
      en_q    <= 1'b1;
      we_q    <= bus.host_write_enable;
    end else if (access_done) begin
      en_q    <= 1'b0;
      we_q    <= 1'b0;
    end
  end

  assign bus.ram_addr         = addr_q;
  assign bus.ram_write_data   = wdata_q;
  assign bus.ram_write_mask   = wmask_q;
  assign bus.ram_enable       = en_q;
  assign bus.ram_write_enable = we_q;
  assign bus.refresh_overflow = overflow_q;

endmodule
